mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Iterative 32-bit multiply/divide unit executing MULT, MULTU, DIV and DIVU.
- Sits directly upstream of the HI/LO register pair and drives its hi_in/lo_in/hi_write/lo_write inputs.
- Fixed latency: one radix-2 step per clock. The pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand width; hi_out/lo_out are WIDTH bits each; iteration count equals WIDTH.

Ports:
- Clk  input  1  rising-edge clock
- Reset_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  input  WIDTH  rs operand (multiplicand / dividend)
- b  input  WIDTH  rt operand (multiplier / divisor)
- flush  input  1  abort in-flight operation with no HI/LO write
- busy  output  1  operation in progress; start ignored
- done  output  1  one-cycle completion pulse
- hi_out  output  WIDTH  HI result (product high word / remainder)
- lo_out  output  WIDTH  LO result (product low word / quotient)
- hi_write  output  1  HI write strobe, equal to done
- lo_write  output  1  LO write strobe, equal to done
- div_by_zero  output  1  set with done when a DIV/DIVU had b==0

Behaviour:
- Interface: one clock (Clk); reset is asynchronous and active-low (Reset_n).
- Reset, asynchronous on Reset_n low:
  - state=IDLE; all outputs 0; internal registers 0.
  - Reset mid-operation discards the operation; no write occurs.
- States: IDLE, RUN, DONE.
- IDLE:
  - On a Clk edge with start=1, latch op, sign flags, |a|, |b| and dz=(b==0); count=0; go to RUN.
  - Magnitudes are used only for signed ops; unsigned ops latch raw operands.
- RUN: one step per edge; count increments; after WIDTH steps go to DONE.
  - Multiply: P={Phi,Plo}, init {0,|a|}. If Plo[0], Phi+=|b| (WIDTH+1-bit sum). Shift {carry,Phi,Plo} right by 1.
  - Divide (restoring): R (WIDTH+1 bits)=0, Q=|a|. Shift {R,Q} left 1. If R>=|b|, set R-=|b| and Q[0]=1.
- DONE lasts exactly one cycle: done=hi_write=lo_write=1, busy=1; next edge goes to IDLE.
- Result registers are loaded on the RUN->DONE edge:
  - MULT: negate the 2*WIDTH product when sign(a)^sign(b).
  - DIV: negate Q when sign(a)^sign(b); negate R when sign(a).
  - Divide by zero, both DIV and DIVU: lo_out=all ones, hi_out=raw a, div_by_zero=1.
  - DIV of 0x80000000 by 0xFFFFFFFF yields lo=0x80000000, hi=0. This needs no special case.
- Latency:
  - Start sampled at edge 0.
  - busy is high from edge 0 through edge WIDTH+1.
  - Write strobes are high in the cycle between edges WIDTH and WIDTH+1 (33 cycles after start for WIDTH=32).
  - HI/LO capture at edge WIDTH+1.
- Holding outputs:
  - hi_out and lo_out hold their last results while IDLE.
  - div_by_zero holds until the next start.
  - Strobes are high only in DONE.
- start while busy, including in the DONE cycle, is ignored and not queued.
- flush=1 in RUN or DONE:
  - Next edge goes to IDLE.
  - If the flush arrives in DONE, strobes are still high for that cycle; the write is combinational from state and the pipeline must not flush a completed op.
  - If flush arrives in RUN, strobes never assert and hi_out/lo_out keep their prior values.
- flush together with start in IDLE: flush wins, start is dropped.
- Signals a, b and op may change after the start edge without effect.

Decomposition:
- Shared package holds:
  - op encodings: OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11;
  - state encodings: IDLE, RUN, DONE;
  - default WIDTH.
- Single module; no sub-module is natural. The step datapath and sign fix are small enough to inline.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at 33 cycles after start: hi=0xFFFFFFFE, lo=0x00000001, hi_write=lo_write=1 for exactly one cycle.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=7 -> lo=0x0000000E, hi=0x00000002. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, div_by_zero=0.
- DIVU a=5 b=0 -> lo=0xFFFFFFFF, hi=0x00000005, div_by_zero=1 with done.
- start MULTU 3*4 -> second start (9*9) pulsed at cycle 10 is ignored, result lo=12; flush at cycle 10 of a new op -> busy low after next edge, no strobes, hi/lo unchanged.
- Reset_n driven low asynchronously mid-RUN -> busy, done, hi_out, lo_out, div_by_zero go to 0 immediately, with no write strobe after release.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// controller states and the default operand width.
package mult_div_unit_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU feeding HI/LO; done/strobes 33 cycles after start.
// No backpressure: busy stalls the pipeline, start while busy is dropped, flush aborts.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             hi_write,
    output logic             lo_write,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [1:0]       op_q, op_d;
    logic             sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
    logic [WIDTH-1:0] araw_q, araw_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             dbz_q, dbz_d;

    logic               in_signed, in_is_div;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH:0]     div_sh, div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_r, div_q, q_fix, r_fix;

    assign in_signed = ~op_q[0];
    assign in_is_div = op_q[1];

    assign a_mag = (~op[0] && a[WIDTH-1]) ? -a : a;
    assign b_mag = (~op[0] && b[WIDTH-1]) ? -b : b;

    // Multiply step: conditional add, then shift {carry,Phi,Plo} right by one.
    assign mul_sum = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? mag_b_q : '0)};
    assign prod    = {mul_sum, acc_lo_q[WIDTH-1:1]};

    // Restoring divide step; shifted remainder < 2*|b|, so diff's top bit is its sign.
    assign div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, mag_b_q};
    assign div_ge   = ~div_diff[WIDTH];
    assign div_r    = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign div_q    = {acc_lo_q[WIDTH-2:0], div_ge};

    assign prod_fix = (sa_q ^ sb_q) ? -prod : prod;
    assign q_fix    = (sa_q ^ sb_q) ? -div_q : div_q;
    assign r_fix    = sa_q ? -div_r : div_r;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        dz_d     = dz_q;
        araw_d   = araw_q;
        mag_b_d  = mag_b_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (!flush && start) begin
                    state_d  = RUN;
                    count_d  = '0;
                    op_d     = op;
                    sa_d     = ~op[0] & a[WIDTH-1];
                    sb_d     = ~op[0] & b[WIDTH-1];
                    dz_d     = (b == '0);
                    araw_d   = a;
                    mag_b_d  = b_mag;
                    acc_hi_d = '0;
                    acc_lo_d = a_mag;
                    dbz_d    = 1'b0;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    count_d = count_q + 1'b1;
                    if (in_is_div) begin
                        acc_hi_d = div_r;
                        acc_lo_d = div_q;
                    end else begin
                        acc_hi_d = prod[2*WIDTH-1:WIDTH];
                        acc_lo_d = prod[WIDTH-1:0];
                    end
                    if (count_q == LAST) begin
                        state_d = DONE;
                        if (!in_is_div) begin
                            hi_d = prod_fix[2*WIDTH-1:WIDTH];
                            lo_d = prod_fix[WIDTH-1:0];
                        end else if (dz_q) begin
                            hi_d  = araw_q;
                            lo_d  = '1;
                            dbz_d = 1'b1;
                        end else begin
                            hi_d = in_signed ? r_fix : div_r;
                            lo_d = in_signed ? q_fix : div_q;
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dz_q     <= 1'b0;
            araw_q   <= '0;
            mag_b_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            dz_q     <= dz_d;
            araw_q   <= araw_d;
            mag_b_q  <= mag_b_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
        end
    end

    // Strobes come from state alone so a flush in DONE cannot cancel a finished write.
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign hi_write    = done;
    assign lo_write    = done;
    assign hi_out      = hi_q;
    assign lo_out      = lo_q;
    assign div_by_zero = dbz_q;

endmodule
